// File: rtl/ti_pkg.sv
// Shared types and helpers for the masked S-box serial front/back end.
package ti_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int W_DEF        = 8;
  localparam int NSHARES_DEF  = 3;
  localparam int NRAND_DEF    = 2;
  localparam int CORE_LAT_DEF = 2;

  // MSB bit position of slot k in a bus of nslots words of w bits; slot 0 is the top word.
  function automatic int slot_msb(input int nslots, input int w, input int k);
    return (nslots - k) * w - 1;
  endfunction

endpackage

// File: rtl/ti_frame_shifter.sv
// NTOT-slot frame load register: word k lands in slot k, in_first restarts at slot 0.
module ti_frame_shifter
  import ti_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NTOT = NSHARES_DEF + NRAND_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              first,
  input  logic [W-1:0]      data,
  output logic [NTOT*W-1:0] frame,
  output logic              done,
  output logic              resync
);

  localparam int IW = $clog2(NTOT + 1);

  logic [IW-1:0] idx;
  logic [IW-1:0] wr_idx;

  always_comb begin
    wr_idx = first ? '0 : idx;
    done   = wr && (wr_idx == IW'(NTOT - 1));
    // Only a restart that abandons already-loaded words is an error.
    resync = wr && first && (idx != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      frame <= '0;
    end else if (wr) begin
      idx <= done ? '0 : wr_idx + 1'b1;
      for (int k = 0; k < NTOT; k++) begin
        if (wr_idx == IW'(k)) frame[slot_msb(NTOT, W, k) -: W] <= data;
      end
    end
  end

endmodule

// File: rtl/ti_sbox_serdes.sv
// Serial front/back end for a masked S-box core: load frame, launch, wait, drain shares.
module ti_sbox_serdes
  import ti_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int NSHARES  = NSHARES_DEF,
  parameter int NRAND    = NRAND_DEF,
  parameter int CORE_LAT = CORE_LAT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic [W-1:0]                 in_data,
  output logic                         in_ready,
  output logic [(NSHARES+NRAND)*W-1:0] core_din,
  output logic                         core_start,
  input  logic [NSHARES*W-1:0]         core_dout,
  output logic                         out_valid,
  output logic [W-1:0]                 out_data,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         frame_err,
  output logic                         busy
);

  localparam int NTOT = NSHARES + NRAND;
  localparam int WCW  = $clog2(CORE_LAT + 1);
  localparam int DCW  = $clog2(NSHARES + 1);

  // Handshakes: a word moves on in_valid && in_ready, a share on out_valid && out_ready;
  // a producer holds valid and data stable until its transfer happens.
  state_t                 state, next_state;
  logic [WCW-1:0]         wait_cnt;
  logic [DCW-1:0]         drain_cnt;
  logic [NSHARES*W-1:0]   out_reg;
  logic                   accept;
  logic                   out_hs;
  logic                   frame_done;
  logic                   resync;
  logic                   lat_hit;

  ti_frame_shifter #(
    .W    (W),
    .NTOT (NTOT)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .wr     (accept),
    .first  (in_first),
    .data   (in_data),
    .frame  (core_din),
    .done   (frame_done),
    .resync (resync)
  );

  always_comb begin
    in_ready   = (state == LOAD);
    busy       = (state != LOAD);
    out_valid  = (state == DRAIN);
    accept     = in_valid && in_ready;
    out_hs     = out_valid && out_ready;
    lat_hit    = (wait_cnt == WCW'(CORE_LAT));
    core_start = (state == WAIT) && (wait_cnt == '0);
    out_last   = out_valid && (drain_cnt == DCW'(NSHARES - 1));
  end

  always_comb begin
    out_data = '0;
    if (state == DRAIN) begin
      for (int j = 0; j < NSHARES; j++) begin
        if (drain_cnt == DCW'(j)) out_data = out_reg[slot_msb(NSHARES, W, j) -: W];
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (frame_done) next_state = WAIT;
      WAIT:    if (lat_hit) next_state = DRAIN;
      DRAIN:   if (out_hs && out_last) next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      drain_cnt <= '0;
      out_reg   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= resync;
      if (state == WAIT) begin
        if (lat_hit) begin
          out_reg  <= core_dout;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
      if (out_hs) drain_cnt <= out_last ? '0 : drain_cnt + 1'b1;
    end
  end

endmodule

// File: doc/ti_sbox_serdes.md
Name: ti_sbox_serdes

Overview:
- Parametrised serial front/back end for a threshold-implementation (masked) S-box core.
- Assembles a frame of NSHARES input shares plus NRAND fresh-randomness words from a W-bit valid/ready stream, and launches the core with a one-cycle start.
- Waits CORE_LAT cycles for the core result, then streams the NSHARES output shares back out with backpressure.
- Re-arms for the next frame with no reset in between. The core sits outside this block and connects through the core_* ports.

Parameters:
- W, 8, width of one share/random word.
- NSHARES, 3, number of input shares and output shares (>=2).
- NRAND, 2, number of randomness words per frame (>=0).
- CORE_LAT, 2, cycles from core_start to a valid core_dout (>=1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a word.
- in_first  in  1  qualifies in_data as word 0 of a new frame (resync).
- in_data  in  W  share/random word.
- in_ready  out  1  block accepts a word this cycle.
- core_din  out  (NSHARES+NRAND)*W  assembled frame to the core.
- core_start  out  1  one-cycle launch pulse.
- core_dout  in  NSHARES*W  core result shares.
- out_valid  out  1  out_data holds a share.
- out_data  out  W  output share.
- out_last  out  1  marks the final share of a frame.
- out_ready  in  1  sink accepts.
- frame_err  out  1  one-cycle pulse: frame restarted by in_first mid-frame.
- busy  out  1  high in WAIT or DRAIN.

Behaviour:
- Reset values (same cycle rst is sampled high):
  - state LOAD, in_ready=1.
  - out_valid=0, out_data=0, out_last=0.
  - core_start=0, core_din=0, frame_err=0, busy=0.
  - Load, wait and drain counters = 0.
- Reset mid-operation discards the partial frame and any pending output. No core_start is issued for it.
- Define NTOT=NSHARES+NRAND. Word k (k=0 first accepted) is stored in core_din[(NTOT-k)*W-1 -: W].
  - Shares occupy the top NSHARES slots; randomness occupies the bottom NRAND slots.
- Accept event: in_valid && in_ready.
- State LOAD:
  - in_ready=1.
  - Each accept writes slot idx and increments idx.
  - An accept with in_first=1 writes slot 0 and sets idx=1.
    - If idx was nonzero, frame_err pulses the next cycle and the old partial words are ignored.
    - in_first on the first word of a frame is legal; no error.
  - An accept at idx=NTOT-1 (or at idx=0 with NTOT=1) completes the frame:
    - next cycle: state WAIT, in_ready=0, core_start=1 for exactly one cycle, busy=1.
- State WAIT:
  - in_ready=0.
  - core_din is held stable from the core_start cycle until the drain completes.
  - The wait counter counts cycles after core_start. In the cycle CORE_LAT cycles after core_start, core_dout is captured into the output register.
  - Next cycle: state DRAIN, out_valid=1, out_data = share 0 = core_dout[NSHARES*W-1 -: W].
- State DRAIN:
  - Output handshake: out_valid && out_ready. Each handshake advances to share j, core_dout slot [(NSHARES-j)*W-1 -: W] of the captured value.
  - out_data/out_valid/out_last are held stable while out_ready=0.
  - out_last=1 only while share NSHARES-1 is presented.
  - On the handshake of the last share: next cycle state LOAD, out_valid=0, out_last=0, in_ready=1, busy=0, idx=0.
  - in_valid is ignored outside LOAD, since in_ready=0 there. No word is lost or double-counted.
- Counter widths: $clog2 of (NTOT+1), (CORE_LAT+1) and (NSHARES+1) respectively. No wrap is possible; each counter clears on its state exit.
- Minimum frame period: NTOT + 1 + CORE_LAT + NSHARES cycles with in_valid and out_ready held high.

Decomposition:
- Shared package ti_pkg:
  - state enum {LOAD, WAIT, DRAIN};
  - default W/NSHARES/NRAND constants;
  - a slot-index function returning the MSB position of slot k.
- One natural sub-module, ti_frame_shifter: the NTOT-slot load register with index and in_first resync. Counters and the FSM stay in the top module.

Test Plan:
- Defaults; bench core returns core_din top 24 bits XOR 24'hA5A5A5 after 2 cycles. Feed 11,22,33,44,55 back-to-back, out_ready=1:
  - core_start pulses 1 cycle after the 5th accept;
  - outputs B4, 87, 96 on consecutive cycles, out_last on 96;
  - in_ready returns the cycle after.
- Same frame with out_ready toggling 1,0,0,1,0,1 -> each share held while stalled, exactly 3 handshakes, no duplicates.
- Feed 11,22 then 77 with in_first=1, then 88,99,AA,BB:
  - frame_err pulses once;
  - frame = 77,88,99,AA,BB; outputs D2, 2D, 3C.
- Assert rst during WAIT (1 cycle) -> no outputs; all outputs at reset values; the next full frame processes normally.
- NSHARES=4, NRAND=0, CORE_LAT=3, identity core; feed 01..04 -> outputs 01,02,03,04, out_last on 04, core_start 1 cycle after 4th accept.
- Two frames with continuous in_valid -> in_ready=0 through WAIT/DRAIN; second frame starts exactly the cycle after the first frame's last output handshake.
